// File: rtl/jesd204_tx_link_fsm.sv
// JESD204B transmit link-layer sequencer: steps the lanes through CGS, ILAS and DATA
// on LMFC boundaries in response to the receiver's active-low SYNC~.
module jesd204_tx_link_fsm #(
    parameter int NUM_LANES     = 1,
    parameter int NUM_LINKS     = 1,
    parameter int RESYNC_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] cfg_lanes_disable,
    input  logic [NUM_LINKS-1:0] cfg_links_disable,
    input  logic                 cfg_skip_ilas,
    input  logic [7:0]           cfg_mframes_per_ilas,
    input  logic                 cfg_continuous_cgs,
    input  logic [NUM_LINKS-1:0] sync,
    input  logic                 lmfc_edge,
    output logic [NUM_LANES-1:0] tx_cgs_en,
    output logic [NUM_LANES-1:0] tx_ilas_en,
    output logic [NUM_LANES-1:0] tx_data_en,
    output logic [7:0]           ilas_mframe,
    output logic [1:0]           status_state,
    output logic [NUM_LINKS-1:0] status_sync,
    output logic                 event_err_report
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [7:0] RESYNC_LAST = 8'(RESYNC_CYCLES - 1);

    state_t               state;
    logic [NUM_LINKS-1:0] sync_m, sync_s;
    logic                 sync_ok;
    logic [7:0]           low_cnt;
    logic [7:0]           ilas_last;

    // SYNC~ is asynchronous to clk; idle-high so reset looks like "released".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_m <= '1;
            sync_s <= '1;
        end else begin
            sync_m <= sync;
            sync_s <= sync_m;
        end
    end

    assign sync_ok     = &(sync_s | cfg_links_disable);
    assign status_sync = sync_s;
    assign ilas_last   = (cfg_mframes_per_ilas == 8'd0) ? 8'd0 : cfg_mframes_per_ilas - 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            ilas_mframe      <= 8'd0;
            low_cnt          <= 8'd0;
            event_err_report <= 1'b0;
        end else begin
            event_err_report <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_CGS;
                ST_CGS: begin
                    low_cnt     <= 8'd0;
                    ilas_mframe <= 8'd0;
                    if (lmfc_edge && sync_ok && !cfg_continuous_cgs)
                        state <= cfg_skip_ilas ? ST_DATA : ST_ILAS;
                end
                ST_ILAS: begin
                    if (cfg_continuous_cgs || !sync_ok) begin
                        state       <= ST_CGS;
                        ilas_mframe <= 8'd0;
                    end else if (lmfc_edge) begin
                        // >= keeps a mid-ILAS shrink of the config from overrunning
                        if (ilas_mframe >= ilas_last)
                            state <= ST_DATA;
                        else
                            ilas_mframe <= ilas_mframe + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (cfg_continuous_cgs) begin
                        state   <= ST_CGS;
                        low_cnt <= 8'd0;
                    end else if (!sync_ok) begin
                        if (low_cnt >= RESYNC_LAST) begin
                            state   <= ST_CGS;
                            low_cnt <= 8'd0;
                        end else if (low_cnt != 8'hFF) begin
                            low_cnt <= low_cnt + 8'd1;
                        end
                    end else begin
                        // a short SYNC~ dip is an error report, not a resync
                        if (low_cnt >= 8'd1 && low_cnt < RESYNC_LAST)
                            event_err_report <= 1'b1;
                        low_cnt <= 8'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign status_state = state;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign tx_cgs_en[i]  = ~cfg_lanes_disable[i] & (state == ST_IDLE || state == ST_CGS);
        assign tx_ilas_en[i] = ~cfg_lanes_disable[i] & (state == ST_ILAS);
        assign tx_data_en[i] = ~cfg_lanes_disable[i] & (state == ST_DATA);
    end

endmodule

// File: tb/tb_jesd204_tx_link_fsm.sv
// Scenario bench for jesd204_tx_link_fsm: each tick queues the expected snapshot,
// the DUT snapshot is queued after the edge, and each scenario drains and compares.
module tb_jesd204_tx_link_fsm;

    typedef struct packed {
        logic [1:0] st;
        logic       err;
        logic [7:0] mf;
        logic [1:0] cgs;
        logic [1:0] ilas;
        logic [1:0] data;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] lanes_dis = 2'b00;
    logic [1:0] links_dis = 2'b00;
    logic       skip = 1'b0;
    logic [7:0] mframes = 8'd4;
    logic       cont = 1'b0;
    logic [1:0] sync_pin = 2'b11;
    logic       lmfc_edge = 1'b0;

    logic [1:0] tx_cgs_en, tx_ilas_en, tx_data_en;
    logic [7:0] ilas_mframe;
    logic [1:0] status_state;
    logic [1:0] status_sync;
    logic       event_err_report;

    snap_t exp_q[$];
    snap_t obs_q[$];
    bit    chk_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    jesd204_tx_link_fsm #(.NUM_LANES(2), .NUM_LINKS(2), .RESYNC_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .cfg_lanes_disable(lanes_dis), .cfg_links_disable(links_dis),
        .cfg_skip_ilas(skip), .cfg_mframes_per_ilas(mframes),
        .cfg_continuous_cgs(cont), .sync(sync_pin), .lmfc_edge(lmfc_edge),
        .tx_cgs_en(tx_cgs_en), .tx_ilas_en(tx_ilas_en), .tx_data_en(tx_data_en),
        .ilas_mframe(ilas_mframe), .status_state(status_state),
        .status_sync(status_sync), .event_err_report(event_err_report)
    );

    always #5 clk = ~clk;

    // mf < 0 means ilas_mframe is not checked on that tick
    task automatic tick(input logic lmfc, input logic [1:0] st, input logic err, input int mf);
        snap_t e, o;
        e.st   = st;
        e.err  = err;
        e.mf   = (mf < 0) ? 8'd0 : 8'(mf);
        e.cgs  = (st <= 2'd1) ? ~lanes_dis : 2'b00;
        e.ilas = (st == 2'd2) ? ~lanes_dis : 2'b00;
        e.data = (st == 2'd3) ? ~lanes_dis : 2'b00;
        exp_q.push_back(e);
        chk_q.push_back(mf >= 0);
        lmfc_edge = lmfc;
        @(posedge clk);
        #1;
        o.st = status_state; o.err = event_err_report; o.mf = ilas_mframe;
        o.cgs = tx_cgs_en; o.ilas = tx_ilas_en; o.data = tx_data_en;
        obs_q.push_back(o);
        lmfc_edge = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 2'd0, 1'b0, 0);
        tick(1'b0, 2'd0, 1'b0, 0);
        reset = 1'b0;
    endtask

    task automatic go_data();
        skip = 1'b1; sync_pin = 2'b11;
        do_reset();
        tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd3, 1'b0, -1);
        skip = 1'b0;
        tick(1'b0, 2'd3, 1'b0, -1);
    endtask

    task automatic test_reset();
        snap_t e, o;
        bit c;
        int idx = 0;
        sync_pin = 2'b00;
        do_reset();
        n_checks++;
        if (status_sync !== 2'b11) $display("FAIL reset_sync: got %b want 11", status_sync);
        else n_pass++;
        tick(1'b0, 2'd1, 1'b0, 0);
        n_checks++;
        if (status_sync !== 2'b11) $display("FAIL sync_latency1: got %b want 11", status_sync);
        else n_pass++;
        tick(1'b0, 2'd1, 1'b0, 0);
        n_checks++;
        if (status_sync !== 2'b00) $display("FAIL sync_latency2: got %b want 00", status_sync);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL reset #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_bringup();
        snap_t e, o;
        bit c;
        int idx = 0;
        sync_pin = 2'b11; mframes = 8'd4;
        do_reset();
        tick(1'b0, 2'd1, 1'b0, 0);
        for (int i = 0; i < 31; i++) tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd2, 1'b0, 0);
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 31; i++) tick(1'b0, 2'd2, 1'b0, m);
            if (m < 3) tick(1'b1, 2'd2, 1'b0, m + 1);
            else       tick(1'b1, 2'd3, 1'b0, -1);
        end
        for (int i = 0; i < 5; i++) tick(1'b0, 2'd3, 1'b0, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL bringup #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_sync_release();
        snap_t e, o;
        bit c;
        int idx = 0;
        sync_pin = 2'b00;
        do_reset();
        for (int i = 0; i < 40; i++) tick(i == 20, 2'd1, 1'b0, 0);
        sync_pin = 2'b11;
        tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd1, 1'b0, 0);   // edge one cycle after release: too early
        for (int i = 0; i < 30; i++) tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd2, 1'b0, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd2, 1'b0, 0);
        tick(1'b1, 2'd2, 1'b0, 1);
        tick(1'b0, 2'd2, 1'b0, 1);
        sync_pin = 2'b00;
        tick(1'b0, 2'd2, 1'b0, 1);
        tick(1'b0, 2'd2, 1'b0, 1);
        tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd1, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL sync_release #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_err_report();
        snap_t e, o;
        bit c;
        int idx = 0;
        int lows[4] = '{3, 1, 6, 7};
        go_data();
        foreach (lows[k]) begin
            sync_pin = 2'b00;
            for (int i = 0; i < lows[k]; i++) tick(1'b0, 2'd3, 1'b0, -1);
            sync_pin = 2'b11;
            for (int i = 0; i < 5; i++) tick(1'b0, 2'd3, (i == 2 && lows[k] <= 6), -1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL err_report #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_resync();
        snap_t e, o;
        bit c;
        int idx = 0;
        go_data();
        sync_pin = 2'b00;
        for (int i = 0; i < 20; i++) tick(1'b0, (i >= 9) ? 2'd1 : 2'd3, 1'b0, -1);
        sync_pin = 2'b11;
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd1, 1'b0, -1);
        tick(1'b1, 2'd2, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL resync #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_skip_ilas();
        snap_t e, o;
        bit c;
        int idx = 0;
        skip = 1'b1; mframes = 8'd0; sync_pin = 2'b11;
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd3, 1'b0, -1);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd3, 1'b0, -1);
        skip = 1'b0; cont = 1'b1;
        tick(1'b0, 2'd1, 1'b0, -1);
        tick(1'b1, 2'd1, 1'b0, 0);   // continuous CGS ignores the LMFC edge
        cont = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b1, 2'd2, 1'b0, 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 2'd2, 1'b0, 0);
        tick(1'b1, 2'd3, 1'b0, -1);
        tick(1'b0, 2'd3, 1'b0, -1);
        cont = 1'b1;
        tick(1'b0, 2'd1, 1'b0, -1);
        cont = 1'b0;
        tick(1'b1, 2'd2, 1'b0, 0);
        tick(1'b0, 2'd2, 1'b0, 0);
        cont = 1'b1;
        tick(1'b0, 2'd1, 1'b0, 0);
        cont = 1'b0; mframes = 8'd4;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL skip_ilas #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_multi_link();
        snap_t e, o;
        bit c;
        int idx = 0;
        links_dis = 2'b10; lanes_dis = 2'b10; mframes = 8'd4; sync_pin = 2'b00;
        do_reset();
        tick(1'b0, 2'd1, 1'b0, 0);
        for (int i = 0; i < 10; i++) tick(i == 5, 2'd1, 1'b0, 0);
        sync_pin = 2'b01;
        tick(1'b0, 2'd1, 1'b0, 0);
        tick(1'b0, 2'd1, 1'b0, 0);
        n_checks++;
        if (status_sync !== 2'b01) $display("FAIL multi_link_sync: got %b want 01", status_sync);
        else n_pass++;
        tick(1'b1, 2'd2, 1'b0, 0);
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd2, 1'b0, 0);
        tick(1'b1, 2'd2, 1'b0, 1);
        tick(1'b0, 2'd2, 1'b0, 1);
        reset = 1'b1;
        tick(1'b0, 2'd0, 1'b0, 0);
        reset = 1'b0;
        tick(1'b0, 2'd1, 1'b0, 0);
        links_dis = 2'b00; lanes_dis = 2'b00;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); c = chk_q.pop_front();
            if (!c) begin e.mf = 8'd0; o.mf = 8'd0; end
            n_checks++;
            if (o !== e) $display("FAIL multi_link #%0d: got st=%0d err=%b mf=%0d en=%b_%b_%b want st=%0d err=%b mf=%0d en=%b_%b_%b",
                idx, o.st, o.err, o.mf, o.cgs, o.ilas, o.data, e.st, e.err, e.mf, e.cgs, e.ilas, e.data);
            else n_pass++;
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_sync_release();
        test_err_report();
        test_resync();
        test_skip_ilas();
        test_multi_link();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
